// File: rtl/alu_serial_pkg.sv
// ----------------------------------------------------------------------------
// alu_serial_pkg
// Shared definitions for the bit-serial ALU: word width, ALU_control op
// codes, 1-bit slice operation codes, FSM state enum and the op decoder that
// turns an ALU_control value into slice control settings.
// Optional feature macro used by the users of this package: ALU_SERIAL_OVF_EN.
// ----------------------------------------------------------------------------
package alu_serial_pkg;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 5;

    // ALU_control encodings
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // Slice result-select codes
    localparam logic [1:0] SL_AND  = 2'b00;
    localparam logic [1:0] SL_OR   = 2'b01;
    localparam logic [1:0] SL_ADD  = 2'b10;
    localparam logic [1:0] SL_LESS = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic       a_inv;
        logic       b_inv;
        logic       cin0;       // carry into bit 0
        logic [1:0] op;
        logic       arith;      // ADD/SUB/SLT: carry and overflow are reported
        logic       is_slt;
        logic       supported;
    } ctrl_t;

    function automatic ctrl_t decode_op(input logic [3:0] alu_control);
        ctrl_t c;
        c           = '0;
        c.supported = 1'b1;
        case (alu_control)
            ALU_AND: c.op = SL_AND;
            ALU_OR:  c.op = SL_OR;
            ALU_ADD: begin
                c.op    = SL_ADD;
                c.arith = 1'b1;
            end
            ALU_SUB: begin
                c.op    = SL_ADD;
                c.b_inv = 1'b1;
                c.cin0  = 1'b1;
                c.arith = 1'b1;
            end
            ALU_SLT: begin
                c.op     = SL_LESS;
                c.b_inv  = 1'b1;
                c.cin0   = 1'b1;
                c.arith  = 1'b1;
                c.is_slt = 1'b1;
            end
            ALU_NOR: begin
                c.op    = SL_AND;
                c.a_inv = 1'b1;
                c.b_inv = 1'b1;
            end
            default: c.supported = 1'b0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/alu_serial_slice.sv
// ----------------------------------------------------------------------------
// alu_serial_slice
// Purely combinational 1-bit ALU slice (AND / OR / ADD / LESS) with operand
// inversion, as used in a classic ripple ALU.
// Ports:
//   i_a, i_b              operand bits
//   i_a_invert, i_b_invert invert the operand bits before use
//   i_cin                 carry in
//   i_less                value passed through for the LESS operation
//   i_op                  result select (SL_* codes)
//   o_result              selected result bit
//   o_cout                carry out of the full adder
//   o_set                 raw adder sum bit (the "set" output of the MSB slice)
// ----------------------------------------------------------------------------
module alu_serial_slice
    import alu_serial_pkg::*;
(
    input  logic       i_a,
    input  logic       i_b,
    input  logic       i_a_invert,
    input  logic       i_b_invert,
    input  logic       i_cin,
    input  logic       i_less,
    input  logic [1:0] i_op,
    output logic       o_result,
    output logic       o_cout,
    output logic       o_set
);

    logic w_a;
    logic w_b;

    assign w_a    = i_a ^ i_a_invert;
    assign w_b    = i_b ^ i_b_invert;
    assign o_set  = w_a ^ w_b ^ i_cin;
    assign o_cout = (w_a & w_b) | (w_a & i_cin) | (w_b & i_cin);

    always_comb begin
        o_result = 1'b0;
        case (i_op)
            SL_AND:  o_result = w_a & w_b;
            SL_OR:   o_result = w_a | w_b;
            SL_ADD:  o_result = o_set;
            SL_LESS: o_result = i_less;
            default: o_result = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_serial.sv
// ----------------------------------------------------------------------------
// alu_serial
// Bit-serial 32-bit ALU (AND, OR, ADD, SUB, SLT, NOR). One operand bit pair is
// pushed through a single 1-bit slice per cycle, LSB first; a result is ready
// 32 cycles after the accept edge and held until the consumer takes it.
// Ports:
//   clk_i, rst_n                 clock, asynchronous active-low reset
//   in_valid / in_ready          request handshake (ready only when idle)
//   src1, src2, ALU_control      operands and op, captured on accept
//   out_valid / out_ready        result handshake
//   result, zero, cout           result word, result==0, carry out of bit 31
//   overflow                     signed overflow (only with ALU_SERIAL_OVF_EN)
// Macro: ALU_SERIAL_OVF_EN adds the overflow port and makes SLT signed-correct.
// ----------------------------------------------------------------------------
module alu_serial
    import alu_serial_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] src1,
    input  logic [WORD_W-1:0] src2,
    input  logic [3:0]        ALU_control,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] result,
    output logic              zero,
    output logic              cout
`ifdef ALU_SERIAL_OVF_EN
    ,
    output logic              overflow
`endif
);

    state_t            r_state;
    state_t            w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_carry;
    logic [WORD_W-1:0] r_a;
    logic [WORD_W-1:0] r_b;
    logic [WORD_W-1:0] r_result;
    logic              r_cout;
    logic              r_a_inv;
    logic              r_b_inv;
    logic [1:0]        r_op;
    logic              r_arith;
    logic              r_slt;
    logic              r_supported;

    ctrl_t             w_decode;
    logic              w_accept;
    logic              w_last;
    logic              w_slice_result;
    logic              w_slice_cout;
    logic              w_slice_set;
    logic              w_less;

    assign w_decode  = decode_op(ALU_control);
    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_cnt == CNT_W'(WORD_W - 1));
    assign result    = r_result;
    assign zero      = (r_result == '0);
    assign cout      = r_cout;

    // Operands are shifted right each cycle so the slice always sees bit 0.
    alu_serial_slice u_slice (
        .i_a        (r_a[0]),
        .i_b        (r_b[0]),
        .i_a_invert (r_a_inv),
        .i_b_invert (r_b_inv),
        .i_cin      (r_carry),
        .i_less     (1'b0),
        .i_op       (r_op),
        .o_result   (w_slice_result),
        .o_cout     (w_slice_cout),
        .o_set      (w_slice_set)
    );

`ifdef ALU_SERIAL_OVF_EN
    logic r_ovf;
    logic w_ovf;

    // At bit 31 r_carry holds the carry into the MSB.
    assign w_ovf    = r_carry ^ w_slice_cout;
    assign w_less   = w_slice_set ^ w_ovf;
    assign overflow = r_ovf;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf <= 1'b0;
        end else if (r_state == ST_RUN && w_last) begin
            r_ovf <= r_arith && r_supported && w_ovf;
        end
    end
`else
    assign w_less = w_slice_set;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid) w_state_next = ST_RUN;
            ST_RUN:  if (w_last)   w_state_next = ST_DONE;
            ST_DONE: if (out_ready) w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_result    <= '0;
            r_cout      <= 1'b0;
            r_a_inv     <= 1'b0;
            r_b_inv     <= 1'b0;
            r_op        <= SL_AND;
            r_arith     <= 1'b0;
            r_slt       <= 1'b0;
            r_supported <= 1'b0;
        end else if (w_accept) begin
            r_a         <= src1;
            r_b         <= src2;
            r_cnt       <= '0;
            r_carry     <= w_decode.cin0;
            r_a_inv     <= w_decode.a_inv;
            r_b_inv     <= w_decode.b_inv;
            r_op        <= w_decode.op;
            r_arith     <= w_decode.arith;
            r_slt       <= w_decode.is_slt;
            r_supported <= w_decode.supported;
        end else if (r_state == ST_RUN) begin
            r_a     <= r_a >> 1;
            r_b     <= r_b >> 1;
            r_carry <= w_slice_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                // Final word is fixed up here: SLT collapses to the less bit,
                // unsupported ops report all zero.
                if (!r_supported) begin
                    r_result <= '0;
                end else if (r_slt) begin
                    r_result <= {{(WORD_W-1){1'b0}}, w_less};
                end else begin
                    r_result <= {w_slice_result, r_result[WORD_W-1:1]};
                end
                r_cout <= r_arith && r_supported && w_slice_cout;
            end else begin
                r_result <= {w_slice_result, r_result[WORD_W-1:1]};
            end
        end
    end

endmodule

// File: tb/tb_alu_serial.sv
// ----------------------------------------------------------------------------
// tb_alu_serial
// Self-checking bench for alu_serial: directed cases with literal expectations
// plus randomized operations against an arithmetic reference model.
// Honors ALU_SERIAL_OVF_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_alu_serial;

    logic        clk_i = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [3:0]  ALU_control;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        cout;
`ifdef ALU_SERIAL_OVF_EN
    logic        overflow;
`endif

    alu_serial dut (
        .clk_i       (clk_i),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .src1        (src1),
        .src2        (src2),
        .ALU_control (ALU_control),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .result      (result),
        .zero        (zero),
        .cout        (cout)
`ifdef ALU_SERIAL_OVF_EN
        ,
        .overflow    (overflow)
`endif
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [31:0] r;
        logic        c;
        logic        v;
    } exp_t;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, got, want, $time);
        end
    endtask

    // Reference arithmetic straight from the op definitions.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        exp_t        e;
        logic [32:0] s;
        e = '0;
        s = '0;
        case (op)
            4'b0000: e.r = a & b;
            4'b0001: e.r = a | b;
            4'b1100: e.r = ~(a | b);
            4'b0010: begin
                s   = {1'b0, a} + {1'b0, b};
                e.r = s[31:0];
                e.c = s[32];
                e.v = (a[31] == b[31]) && (s[31] != a[31]);
            end
            4'b0110, 4'b0111: begin
                s   = {1'b0, a} + {1'b0, ~b} + 33'd1;
                e.r = s[31:0];
                e.c = s[32];
                e.v = (a[31] != b[31]) && (s[31] != a[31]);
                if (op == 4'b0111) begin
`ifdef ALU_SERIAL_OVF_EN
                    e.r = {31'b0, ($signed(a) < $signed(b))};
`else
                    e.r = {31'b0, s[31]};
`endif
                end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Protocol model: idle -> 32 cycles busy -> done until taken.
    exp_t       m_exp;
    logic       m_done;
    logic [5:0] m_left;

    always @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            m_done <= 1'b0;
            m_left <= '0;
            m_exp  <= '0;
        end else if (m_done) begin
            if (out_ready) m_done <= 1'b0;
        end else if (m_left != 0) begin
            m_left <= m_left - 6'd1;
            if (m_left == 6'd1) m_done <= 1'b1;
        end else if (in_valid) begin
            m_left <= 6'd32;
            m_exp  <= model(src1, src2, ALU_control);
        end
    end

    always @(negedge clk_i) begin
        if (rst_n) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, m_done});
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!m_done && m_left == 0)});
            if (m_done) begin
                chk("result", result, m_exp.r);
                chk("zero", {31'b0, zero}, {31'b0, (m_exp.r == 32'd0)});
                chk("cout", {31'b0, cout}, {31'b0, m_exp.c});
`ifdef ALU_SERIAL_OVF_EN
                chk("overflow", {31'b0, overflow}, {31'b0, m_exp.v});
`endif
            end
        end
    end

    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op,
                         input int hold, input bit lit, input logic [31:0] want_r,
                         input logic want_z, input logic want_c, input logic want_v,
                         input string tag);
        int guard;
        int lat;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(negedge clk_i);
            guard++;
        end
        chk({tag, "_ready_timeout"}, (guard >= 200) ? 32'd1 : 32'd0, 32'd0);
        src1        = a;
        src2        = b;
        ALU_control = op;
        in_valid    = 1'b1;
        @(negedge clk_i);
        // Scramble inputs during RUN; one in_valid pulse must be ignored.
        src1        = $urandom;
        src2        = $urandom;
        ALU_control = 4'($urandom);
        in_valid    = 1'b0;
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(negedge clk_i);
            lat++;
            in_valid = (lat == 5);
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, lat, 32);
        if (lit) begin
            chk({tag, "_lit_result"}, result, want_r);
            chk({tag, "_lit_zero"}, {31'b0, zero}, {31'b0, want_z});
            chk({tag, "_lit_cout"}, {31'b0, cout}, {31'b0, want_c});
`ifdef ALU_SERIAL_OVF_EN
            chk({tag, "_lit_overflow"}, {31'b0, overflow}, {31'b0, want_v});
`endif
        end
        for (int i = 0; i < hold; i++) begin
            out_ready   = 1'b0;
            in_valid    = 1'($urandom);
            src1        = $urandom;
            ALU_control = 4'($urandom);
            @(negedge clk_i);
        end
        if (lit && hold > 0) begin
            chk({tag, "_hold_result"}, result, want_r);
            chk({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk_i);
        out_ready = 1'b0;
        chk({tag, "_back_idle"}, {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ops [8];
        logic [31:0] specials [6];
        logic [31:0] a;
        logic [31:0] b;
        ops      = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b0011, 4'b1111};
        specials = '{32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'h1, 32'h5};

        rst_n       = 1'b0;
        in_valid    = 1'b0;
        out_ready   = 1'b0;
        src1        = '0;
        src2        = '0;
        ALU_control = '0;
        repeat (2) @(negedge clk_i);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_cout", {31'b0, cout}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk_i);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        do_op(32'h7FFFFFFF, 32'h00000001, 4'b0010, 0, 1'b1, 32'h80000000, 1'b0, 1'b0, 1'b1, "add_ovf");
        do_op(32'h5, 32'h5, 4'b0110, 0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b0, "sub_eq");
        do_op(32'hFFFFFFFF, 32'h1, 4'b0111, 1, 1'b1, 32'h1, 1'b0, 1'b1, 1'b0, "slt_neg1");
`ifdef ALU_SERIAL_OVF_EN
        do_op(32'h80000000, 32'h1, 4'b0111, 0, 1'b1, 32'h1, 1'b0, 1'b1, 1'b1, "slt_min");
`else
        do_op(32'h80000000, 32'h1, 4'b0111, 0, 1'b1, 32'h0, 1'b1, 1'b1, 1'b1, "slt_min");
`endif
        do_op(32'h0, 32'h0, 4'b1100, 0, 1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, "nor_zero");
        do_op(32'hF0F0F0F0, 32'hFF00FF00, 4'b0000, 10, 1'b1, 32'hF000F000, 1'b0, 1'b0, 1'b0, "and_hold");
        do_op(32'h12345678, 32'h9ABCDEF0, 4'b0011, 0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b0, "unsupported");

        // Reset in the middle of an ADD (during bit 15).
        src1        = 32'hFFFFFFFF;
        src2        = 32'h1;
        ALU_control = 4'b0010;
        in_valid    = 1'b1;
        @(negedge clk_i);
        in_valid = 1'b0;
        repeat (15) @(negedge clk_i);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_result", result, 32'd0);
        @(negedge clk_i);
        rst_n = 1'b1;
        @(negedge clk_i);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        do_op(32'h12345678, 32'h11111111, 4'b0010, 0, 1'b1, 32'h23456789, 1'b0, 1'b0, 1'b0, "after_rst");

        for (int n = 0; n < 40; n++) begin
            a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            b = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
            if ($urandom_range(0, 7) == 0) b = a;
            do_op(a, b, ops[$urandom_range(0, 7)], $urandom_range(0, 3), 1'b0,
                  32'h0, 1'b0, 1'b0, 1'b0, "rand");
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
